led_pattern_blinker: RTL and testbench
======================================

# led_pattern_blinker

Multi-channel LED pattern generator for the lock's user-feedback path. The controller selects one of four predefined blink patterns and an LED mask, then pulses `start`. The block drives the masked LEDs through timed ON/OFF phases for a fixed blink count, or continuously, and reports completion with a one-cycle `done` pulse. It supports retrigger and abort, and its timing is scaled through a parametrised prescaler.

## Interface
- `NUM_LEDS`, 4: number of LED outputs.
- `TICK_DIV`, 1200: `hwclk` cycles per tick (0.1 ms at 12 MHz). Must be ≥1.
- `TIMER_W`, 16: phase timer width. Must hold the largest ON/OFF tick count.
- `CNT_W`, 4: blink counter width.
- `hwclk` in 1: system clock. Everything is synchronous to its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request, sampled on the rising edge of `hwclk`.
- `pattern_sel` in 2: pattern index, sampled together with `start`.
- `led_mask` in `NUM_LEDS`: LEDs that participate, sampled together with `start`.
- `abort` in 1: stops any pattern in progress.
- `leds` out `NUM_LEDS`: LED drive, 1 = lit.
- `busy` out 1: high while a pattern is running.
- `done` out 1: one-cycle pulse when a finite pattern completes.

## Operation
- Pattern table, in ticks (ON / OFF / blinks):
  - 0 ERROR: 5000 / 10000 / 3
  - 1 SUCCESS: 2000 / 2000 / 5
  - 2 ACK: 1000 / 1000 / 1
  - 3 HEARTBEAT: 500 / 9500 / 0, where 0 means continuous until `abort` or retrigger
- FSM states: IDLE, ON, OFF.
- IDLE:
  - `leds` = 0, `busy` = 0.
  - On `start`: latch `pattern_sel` and `led_mask`, load the remaining-blink count from the table, clear the prescaler and phase timer, go to ON.
- ON:
  - `leds` = latched mask.
  - When the phase timer reaches ON−1 on a tick, clear the timer and go to OFF.
- OFF:
  - `leds` = 0.
  - When the timer reaches OFF−1 on a tick, clear the timer.
  - If the count is 0 (continuous), go to ON.
  - Else if remaining = 1, go to IDLE and pulse `done`.
  - Else decrement remaining and go to ON.
- Retrigger: `start` while `busy` restarts immediately with the new pattern and mask. No `done` is issued for the interrupted pattern.
- Abort:
  - `abort` in ON or OFF goes to IDLE on the next edge with `leds` = 0 and no `done`.
  - `abort` in IDLE has no effect.
  - `abort` and `start` asserted in the same cycle: `abort` wins and `start` is dropped.
- Prescaler: raises `tick` for one cycle every `TICK_DIV` cycles. It is held cleared in IDLE and cleared on every `start`.
- A mask of 0 is legal. The sequence runs with `leds` dark and `busy`/`done` still behave normally.

## Timing
- Reset values: `leds` = 0, `busy` = 0, `done` = 0, state IDLE, all counters 0.
- Reset asserted mid-pattern forces IDLE immediately, asynchronously, with no `done`.
- Let `start` be sampled at edge N.
  - `busy` = 1 and `leds` = mask from cycle N+1.
  - Each ON phase lasts exactly ON·`TICK_DIV` cycles; each OFF phase lasts exactly OFF·`TICK_DIV` cycles.
- Finite pattern with count C:
  - `busy` stays high for C·(ON+OFF)·`TICK_DIV` cycles.
  - `done` is high in the first IDLE cycle, coincident with `busy` falling. `done` never overlaps `busy`=1.
- A `start` accepted in the same cycle as `done` begins the new pattern in the following cycle.
- Arithmetic: all counters are unsigned and saturate-free. The table is constrained so that no counter wraps.

## Structure
- Package `blink_pkg` contains:
  - The `blink_state_t` enum (IDLE/ON/OFF).
  - The `pattern_t` enum (ERROR/SUCCESS/ACK/HEARTBEAT).
  - The constant ON, OFF and COUNT arrays indexed by `pattern_t`.
- Sub-module `blink_prescaler` (parameter `TICK_DIV`; ports `hwclk`, `rst_n`, `clr`, `tick`) generates `tick`.
- The top level holds the FSM, the phase timer, the blink counter and the latched mask.

## Test plan
- Use `TICK_DIV`=1 for all scenarios.
- Reset: hold `rst_n` low, then release → `leds`=0, `busy`=0, `done`=0; they stay 0 with no `start`.
- Pattern 2, mask 4'b0101 → `leds`=0101 for 1000 cycles, then 0 for 1000 cycles; `done` pulses once at cycle 2001 after start; `busy` high for exactly 2000 cycles.
- Pattern 0, mask 4'b1111 → 3 ON windows of 5000 cycles; `done` after 45000 cycles; exactly 3 rising edges on `leds[0]`.
- Pattern 3 → blinking continues past 100000 cycles with no `done`; `abort` → `leds`=0 and `busy`=0 on the next cycle, no `done`.
- Pattern 1 running, retrigger with pattern 2 at cycle 3000 → new 1000-cycle ON phase starts the next cycle; exactly one `done`, at 2000 cycles after the retrigger.
- `start` and `abort` asserted together in IDLE → no activity. Reset asserted mid-OFF → immediate IDLE, no `done`.

Source files
------------

// File: rtl/led_pattern_blinker_pkg.sv
// Shared types and the blink pattern table for the LED pattern blinker.
// Table entries are in prescaler ticks; a COUNT of 0 means run until abort or retrigger.
package blink_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } blink_state_t;

  typedef enum logic [1:0] {
    PatError,
    PatSuccess,
    PatAck,
    PatHeartbeat
  } pattern_t;

  localparam int unsigned ON    [4] = '{5000, 2000, 1000, 500};
  localparam int unsigned OFF   [4] = '{10000, 2000, 1000, 9500};
  localparam int unsigned COUNT [4] = '{3, 5, 1, 0};

endpackage

// File: rtl/led_pattern_blinker_if.sv
// Request/status bundle between the lock controller and the LED pattern blinker.
interface led_pattern_blinker_if #(
  parameter int unsigned NUM_LEDS = 4
) ();

  logic                start;
  logic [1:0]          pattern_sel;
  logic [NUM_LEDS-1:0] led_mask;
  logic                abort;
  logic [NUM_LEDS-1:0] leds;
  logic                busy;
  logic                done;

  modport master (
    output start, pattern_sel, led_mask, abort,
    input  leds, busy, done
  );

  modport slave (
    input  start, pattern_sel, led_mask, abort,
    output leds, busy, done
  );

endinterface

// File: rtl/led_pattern_blinker_prescaler.sv
// Tick generator: one-cycle tick every TICK_DIV cycles, restarted whenever clr is high.
module blink_prescaler #(
  parameter int unsigned TICK_DIV = 1200
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Suppressed while clearing so a restart never sees a stale tick.
  assign tick = !clr && (cnt_q == CntMax);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_blinker.sv
// Multi-channel LED pattern generator: timed ON/OFF phases over a latched mask,
// finite or continuous, with retrigger, abort and a one-cycle done pulse.
module led_pattern_blinker
  import blink_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned TICK_DIV = 1200,
  parameter int unsigned TIMER_W  = 16,
  parameter int unsigned CNT_W    = 4
) (
  input  logic hwclk,
  input  logic rst_n,
  led_pattern_blinker_if.slave bus
);

  blink_state_t        state_q;
  pattern_t            pat_q;
  logic [NUM_LEDS-1:0] mask_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [NUM_LEDS-1:0] leds_q;
  logic                busy_q;
  logic                done_q;

  logic               start_go;
  logic               clr;
  logic               tick;
  logic [TIMER_W-1:0] phase_end;
  logic               phase_done;

  // Abort always beats a simultaneous start, even in idle.
  assign start_go = bus.start && !bus.abort;
  assign clr      = (state_q == StIdle) || start_go;

  blink_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    phase_end = '0;
    if (state_q == StOn) begin
      phase_end = TIMER_W'(ON[pat_q] - 1);
    end else if (state_q == StOff) begin
      phase_end = TIMER_W'(OFF[pat_q] - 1);
    end
  end

  assign phase_done = tick && (timer_q == phase_end);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pat_q       <= PatError;
      mask_q      <= '0;
      timer_q     <= '0;
      remaining_q <= '0;
      leds_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort && (state_q != StIdle)) begin
        state_q     <= StIdle;
        timer_q     <= '0;
        remaining_q <= '0;
        leds_q      <= '0;
        busy_q      <= 1'b0;
      end else if (start_go) begin
        state_q     <= StOn;
        pat_q       <= pattern_t'(bus.pattern_sel);
        mask_q      <= bus.led_mask;
        remaining_q <= CNT_W'(COUNT[bus.pattern_sel]);
        timer_q     <= '0;
        leds_q      <= bus.led_mask;
        busy_q      <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            timer_q <= '0;
          end
          StOn: begin
            if (phase_done) begin
              timer_q <= '0;
              state_q <= StOff;
              leds_q  <= '0;
            end else if (tick) begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StOff: begin
            if (phase_done) begin
              timer_q <= '0;
              if (remaining_q == '0) begin
                state_q <= StOn;
                leds_q  <= mask_q;
              end else if (remaining_q == CNT_W'(1)) begin
                state_q     <= StIdle;
                remaining_q <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                remaining_q <= remaining_q - 1'b1;
                state_q     <= StOn;
                leds_q      <= mask_q;
              end
            end else if (tick) begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.leds = leds_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_led_pattern_blinker.sv
// Bench for led_pattern_blinker at TICK_DIV=1: directed scenarios plus random
// traffic, all traced cycle by cycle against a time-since-start reference model.
module tb_led_pattern_blinker;

  localparam int unsigned NumLeds = 4;
  localparam int unsigned ON_T  [4] = '{5000, 2000, 1000, 500};
  localparam int unsigned OFF_T [4] = '{10000, 2000, 1000, 9500};
  localparam int unsigned CNT_T [4] = '{3, 5, 1, 0};

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  led_pattern_blinker_if #(.NUM_LEDS(NumLeds)) bus ();

  led_pattern_blinker #(
    .NUM_LEDS (NumLeds),
    .TICK_DIV (1),
    .TIMER_W  (16),
    .CNT_W    (4)
  ) dut (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 hwclk = ~hwclk;

  // Reference model: expected outputs follow from cycles elapsed since the accepted start.
  logic               m_active;
  logic               m_done;
  int unsigned        m_t;
  int unsigned        m_pat;
  logic [NumLeds-1:0] m_mask;
  logic [NumLeds-1:0] exp_leds;

  always @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
      m_pat    <= 0;
      m_mask   <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.abort) begin
        m_active <= 1'b0;
      end else if (bus.start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_pat    <= int'(bus.pattern_sel);
        m_mask   <= bus.led_mask;
      end else if (m_active) begin
        if (CNT_T[m_pat] != 0 && m_t + 1 == CNT_T[m_pat] * (ON_T[m_pat] + OFF_T[m_pat])) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  always_comb begin
    exp_leds = '0;
    if (m_active && ((m_t % (ON_T[m_pat] + OFF_T[m_pat])) < ON_T[m_pat])) exp_leds = m_mask;
  end

  // Continuous trace comparison against the model on the falling edge.
  always @(negedge hwclk) begin
    checks++;
    if (bus.leds !== exp_leds || bus.busy !== m_active || bus.done !== m_done) begin
      errors++;
      $display("FAIL trace @%0t: leds=%b busy=%b done=%b, required leds=%b busy=%b done=%b",
               $time, bus.leds, bus.busy, bus.done, exp_leds, m_active, m_done);
    end
  end

  task automatic drive_start(input logic [1:0] pat, input logic [NumLeds-1:0] mask,
                             input logic with_abort);
    bus.start       = 1'b1;
    bus.pattern_sel = pat;
    bus.led_mask    = mask;
    bus.abort       = with_abort;
    @(negedge hwclk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.pattern_sel = '0; bus.led_mask = '0; bus.abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge hwclk);
    checks++;
    if (bus.leds !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: leds=%b busy=%b done=%b, required all 0",
               bus.leds, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge hwclk);
    checks++;
    if (bus.leds !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: leds=%b busy=%b done=%b, required all 0",
               bus.leds, bus.busy, bus.done);
    end
  endtask

  task automatic test_ack();
    int busy_n = 0, on_n = 0, done_n = 0, done_at = 0;
    drive_start(2'd2, 4'b0101, 1'b0);
    for (int k = 1; k <= 2100; k++) begin
      if (bus.busy) busy_n++;
      if (bus.leds === 4'b0101) on_n++;
      if (bus.done) begin done_n++; done_at = k; end
      @(negedge hwclk);
    end
    checks++;
    if (busy_n != 2000) begin
      errors++; $display("FAIL ack_busy_len: got %0d, required 2000", busy_n);
    end
    checks++;
    if (on_n != 1000) begin
      errors++; $display("FAIL ack_on_len: got %0d, required 1000", on_n);
    end
    checks++;
    if (done_n != 1 || done_at != 2001) begin
      errors++;
      $display("FAIL ack_done: got %0d pulses at %0d, required 1 at 2001", done_n, done_at);
    end
  endtask

  task automatic test_error();
    int rises = 0, on_n = 0, done_at = 0;
    logic prev = 1'b0;
    drive_start(2'd0, 4'b1111, 1'b0);
    for (int k = 1; k <= 45100; k++) begin
      if (bus.leds[0] && !prev) rises++;
      prev = bus.leds[0];
      if (bus.leds === 4'b1111) on_n++;
      if (bus.done) done_at = k;
      @(negedge hwclk);
    end
    checks++;
    if (rises != 3) begin
      errors++; $display("FAIL error_rises: got %0d, required 3", rises);
    end
    checks++;
    if (on_n != 15000) begin
      errors++; $display("FAIL error_on_len: got %0d, required 15000", on_n);
    end
    checks++;
    if (done_at != 45001) begin
      errors++; $display("FAIL error_done_at: got %0d, required 45001", done_at);
    end
  endtask

  task automatic test_heartbeat();
    int rises = 0, done_n = 0, busy_n = 0;
    logic prev = 1'b0;
    logic [NumLeds-1:0] mask;
    mask = NumLeds'($urandom) | 4'b0001;
    drive_start(2'd3, mask, 1'b0);
    for (int k = 1; k <= 21000; k++) begin
      if (bus.leds[0] && !prev) rises++;
      prev = bus.leds[0];
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      @(negedge hwclk);
    end
    checks++;
    if (rises != 3 || busy_n != 21000 || done_n != 0) begin
      errors++;
      $display("FAIL heartbeat_run: rises=%0d busy=%0d done=%0d, required 3 21000 0",
               rises, busy_n, done_n);
    end
    bus.abort = 1'b1;
    @(negedge hwclk);
    bus.abort = 1'b0;
    checks++;
    if (bus.leds !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL heartbeat_abort: leds=%b busy=%b done=%b, required all 0",
               bus.leds, bus.busy, bus.done);
    end
    done_n = 0;
    repeat (30) begin if (bus.done) done_n++; @(negedge hwclk); end
    checks++;
    if (done_n != 0) begin
      errors++; $display("FAIL heartbeat_no_done: got %0d pulses, required 0", done_n);
    end
  endtask

  task automatic test_retrigger();
    int done_n = 0, done_at = 0;
    logic [NumLeds-1:0] mask1, mask2;
    mask1 = NumLeds'($urandom);
    mask2 = NumLeds'($urandom_range(1, 15));
    drive_start(2'd1, mask1, 1'b0);
    for (int k = 1; k < 3000; k++) @(negedge hwclk);
    drive_start(2'd2, mask2, 1'b0);
    checks++;
    if (bus.leds !== mask2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL retrigger_on: leds=%b busy=%b, required leds=%b busy=1",
               bus.leds, bus.busy, mask2);
    end
    for (int k = 1; k <= 2100; k++) begin
      if (bus.done) begin done_n++; done_at = k; end
      @(negedge hwclk);
    end
    checks++;
    if (done_n != 1 || done_at != 2001) begin
      errors++;
      $display("FAIL retrigger_done: got %0d pulses at %0d, required 1 at 2001",
               done_n, done_at);
    end
  endtask

  task automatic test_start_abort_idle();
    int active_n = 0;
    drive_start(2'($urandom_range(0, 3)), 4'b1111, 1'b1);
    repeat (50) begin
      if (bus.busy || bus.leds != '0 || bus.done) active_n++;
      @(negedge hwclk);
    end
    checks++;
    if (active_n != 0) begin
      errors++; $display("FAIL start_abort_idle: %0d active cycles, required 0", active_n);
    end
  endtask

  task automatic test_reset_mid_off();
    int done_n = 0;
    drive_start(2'd2, 4'b1111, 1'b0);
    repeat (1500) @(negedge hwclk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.leds !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_off: leds=%b busy=%b done=%b, required all 0",
               bus.leds, bus.busy, bus.done);
    end
    @(negedge hwclk);
    rst_n = 1'b1;
    repeat (30) begin if (bus.done) done_n++; @(negedge hwclk); end
    checks++;
    if (done_n != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d pulses, required 0", done_n);
    end
  endtask

  task automatic test_random();
    int unsigned op;
    for (int i = 0; i < 8; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0, 1: drive_start(2'($urandom_range(1, 3)), NumLeds'($urandom), 1'b0);
        2: begin bus.abort = 1'b1; @(negedge hwclk); bus.abort = 1'b0; end
        default: drive_start(2'($urandom_range(0, 3)), NumLeds'($urandom), 1'b1);
      endcase
      repeat ($urandom_range(1, 1500)) @(negedge hwclk);
    end
    bus.abort = 1'b1;
    @(negedge hwclk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL random_final_abort: busy=%b, required 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_error();
    test_heartbeat();
    test_retrigger();
    test_start_abort_idle();
    test_reset_mid_off();
    test_random();
    repeat (2) @(negedge hwclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
